mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with load byte/half extraction; one cycle EX->WB, non-loads add no latency.
// Stalls on !WB_allow while holding first-cycle SRAM read data; define MEM_ALIGN_CHECK_EN to flag misaligned loads.
module mem_stage #(
   parameter int EX_BUS_W = 75,
   parameter int WB_BUS_W = 70,
   parameter int FWD_W    = 38
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                WB_allow,
   output logic                MEM_allow,
   input  logic                EX_to_MEM_valid,
   input  logic [EX_BUS_W-1:0] EX_to_MEM_bus,
   input  logic [31:0]         data_sram_rdata,
   output logic                MEM_to_WB_valid,
   output logic [WB_BUS_W-1:0] MEM_to_WB_bus,
   output logic [FWD_W-1:0]    MEM_to_ID_forward,
   output logic                mem_ale
);

   typedef struct packed {
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
      logic        ld_b;
      logic        ld_h;
      logic        ld_bu;
      logic        ld_hu;
   } ex_bus_t;

   ex_bus_t     bus_q;
   logic        mem_valid_q, mem_valid_d;
   logic        hold_vld_q, hold_vld_d;
   logic [31:0] hold_q, hold_d;
   logic        mem_ready_go;
   logic [31:0] rdata;
   logic [1:0]  addr;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;
   logic [31:0] final_result;
   logic        gr_we_eff;

   assign mem_ready_go    = 1'b1;
   assign MEM_allow       = !mem_valid_q || (mem_ready_go && WB_allow);
   assign MEM_to_WB_valid = mem_valid_q && mem_ready_go;

   // SRAM data is only valid in the first MEM cycle; keep it if WB stalls us
   always_comb begin
      mem_valid_d = MEM_allow ? EX_to_MEM_valid : mem_valid_q;
      hold_vld_d  = hold_vld_q;
      hold_d      = hold_q;
      if (mem_valid_q && WB_allow) begin
         hold_vld_d = 1'b0;
      end else if (mem_valid_q && bus_q.res_from_mem && !hold_vld_q) begin
         hold_vld_d = 1'b1;
         hold_d     = data_sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid_q <= 1'b0;
         hold_vld_q  <= 1'b0;
      end else begin
         mem_valid_q <= mem_valid_d;
         hold_vld_q  <= hold_vld_d;
      end
      hold_q <= hold_d;
      if (EX_to_MEM_valid && MEM_allow) begin
         bus_q <= ex_bus_t'(EX_to_MEM_bus);
      end
   end

   assign rdata = hold_vld_q ? hold_q : data_sram_rdata;
   assign addr  = bus_q.result[1:0];

   always_comb begin
      case (addr)
         2'd0:    ld_byte = rdata[7:0];
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         default: ld_byte = rdata[31:24];
      endcase
      ld_half = addr[1] ? rdata[31:16] : rdata[15:0];
      if (bus_q.ld_b)       ld_val = {{24{ld_byte[7]}}, ld_byte};
      else if (bus_q.ld_bu) ld_val = {24'd0, ld_byte};
      else if (bus_q.ld_h)  ld_val = {{16{ld_half[15]}}, ld_half};
      else if (bus_q.ld_hu) ld_val = {16'd0, ld_half};
      else                  ld_val = rdata;
   end

   assign final_result = bus_q.res_from_mem ? ld_val : bus_q.result;

`ifdef MEM_ALIGN_CHECK_EN
   assign mem_ale = mem_valid_q && bus_q.res_from_mem &&
                    (((bus_q.ld_h || bus_q.ld_hu) && addr[0]) ||
                     (!(bus_q.ld_b || bus_q.ld_bu || bus_q.ld_h || bus_q.ld_hu) && (addr != 2'd0)));
`else
   assign mem_ale = 1'b0;
`endif

   assign gr_we_eff = bus_q.gr_we && !mem_ale;

   assign MEM_to_WB_bus     = {gr_we_eff, bus_q.dest, final_result, bus_q.pc};
   assign MEM_to_ID_forward = {gr_we_eff && mem_valid_q,
                               bus_q.dest & {5{mem_valid_q}},
                               final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed test-plan steps followed by random traffic against a transaction-level model.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        WB_allow;
   logic        MEM_allow;
   logic        EX_to_MEM_valid;
   logic [74:0] EX_to_MEM_bus;
   logic [31:0] data_sram_rdata;
   logic        MEM_to_WB_valid;
   logic [69:0] MEM_to_WB_bus;
   logic [37:0] MEM_to_ID_forward;
   logic        mem_ale;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .WB_allow          (WB_allow),
      .MEM_allow         (MEM_allow),
      .EX_to_MEM_valid   (EX_to_MEM_valid),
      .EX_to_MEM_bus     (EX_to_MEM_bus),
      .data_sram_rdata   (data_sram_rdata),
      .MEM_to_WB_valid   (MEM_to_WB_valid),
      .MEM_to_WB_bus     (MEM_to_WB_bus),
      .MEM_to_ID_forward (MEM_to_ID_forward),
      .mem_ale           (mem_ale)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rfm;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] res;
      logic [31:0] pc;
      logic        b, h, bu, hu;
   } inst_t;

   int errors = 0;
   int checks = 0;

   // reference: instruction occupying MEM and the SRAM word it saw on arrival
   logic        m_v = 1'b0;
   logic        m_first = 1'b0;
   inst_t       m_i;
   logic [31:0] m_rd;

   logic        cur_rst, cur_ev, cur_wa;
   inst_t       cur_i;

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic inst_t mk(input logic rfm, input logic we, input logic [4:0] d,
                                input logic [31:0] res, input logic [31:0] pc, input logic [3:0] fl);
      inst_t i;
      i.rfm = rfm; i.we = we; i.dest = d; i.res = res; i.pc = pc;
      i.b = fl[3]; i.h = fl[2]; i.bu = fl[1]; i.hu = fl[0];
      return i;
   endfunction

   function automatic logic [31:0] expect_val(input inst_t i, input logic [31:0] rd);
      logic [31:0] a, bv, hv;
      if (!i.rfm) return i.res;
      a  = i.res % 4;
      bv = (rd >> (8 * a)) % 256;
      hv = (a >= 2) ? (rd / 65536) : (rd % 65536);
      if (i.b)  return (bv >= 128) ? bv - 32'd256 : bv;
      if (i.bu) return bv;
      if (i.h)  return (hv >= 32768) ? hv - 32'd65536 : hv;
      if (i.hu) return hv;
      return rd;
   endfunction

   function automatic logic expect_ale(input inst_t i);
`ifdef MEM_ALIGN_CHECK_EN
      if (!i.rfm) return 1'b0;
      if (i.h || i.hu) return (i.res % 2) != 0;
      if (!(i.b || i.bu)) return (i.res % 4) != 0;
      return 1'b0;
`else
      return i.rfm && 1'b0;
`endif
   endfunction

   // Drive one cycle's inputs at the falling edge and check against the model.
   task automatic drive(input logic r, input logic ev, input inst_t i,
                        input logic [31:0] rd, input logic wa);
      logic        ale, we;
      logic [31:0] fin;
      @(negedge clk);
      cur_rst = r; cur_ev = ev; cur_i = i; cur_wa = wa;
      reset = r; EX_to_MEM_valid = ev; WB_allow = wa; data_sram_rdata = rd;
      EX_to_MEM_bus = {i.rfm, i.we, i.dest, i.res, i.pc, i.b, i.h, i.bu, i.hu};
      #1;
      if (m_v && m_first) m_rd = rd;
      chk("mem_allow", MEM_allow, !m_v || wa);
      chk("wb_valid", MEM_to_WB_valid, m_v);
      if (m_v) begin
         ale = expect_ale(m_i);
         we  = m_i.we && !ale;
         fin = expect_val(m_i, m_rd);
         chk("wb_bus", MEM_to_WB_bus, {we, m_i.dest, fin, m_i.pc});
         chk("fwd", MEM_to_ID_forward, {we, m_i.dest, fin});
         chk("ale", mem_ale, ale);
      end else begin
         chk("fwd_empty", MEM_to_ID_forward[37:32], 6'd0);
         chk("ale_empty", mem_ale, 1'b0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (cur_rst) begin
         m_v = 1'b0;
      end else if (!m_v || cur_wa) begin
         m_v = cur_ev;
         m_i = cur_i;
         m_first = 1'b1;
      end else begin
         m_first = 1'b0;
      end
   endtask

   task automatic step(input logic r, input logic ev, input inst_t i,
                       input logic [31:0] rd, input logic wa);
      drive(r, ev, i, rd, wa);
      tick();
   endtask

   inst_t nop, ld;

   initial begin
      nop = mk(0, 0, 0, 0, 0, 4'b0000);
      m_i = nop;
      m_rd = 0;
      reset = 1'b1; WB_allow = 1'b1; EX_to_MEM_valid = 1'b0;
      EX_to_MEM_bus = '0; data_sram_rdata = '0;
      cur_rst = 1'b1; cur_ev = 1'b0; cur_wa = 1'b1; cur_i = nop;
      repeat (2) @(posedge clk);

      // reset state
      drive(0, 0, nop, 32'h0, 1);
      chk("rst_wb_valid", MEM_to_WB_valid, 1'b0);
      chk("rst_fwd", MEM_to_ID_forward[37:32], 6'd0);
      chk("rst_allow", MEM_allow, 1'b1);
      tick();

      // ld_b at byte 3 sign-extends 0x80
      step(0, 1, mk(1, 1, 5'd3, 32'h1003, 32'h1C000010, 4'b1000), 32'h0, 1);
      drive(0, 0, nop, 32'h80FF1234, 1);
      chk("ldb_valid", MEM_to_WB_valid, 1'b1);
      chk("ldb_final", MEM_to_WB_bus[63:32], 32'hFFFFFF80);
      tick();

      // ld_hu upper half, then ld_h lower half of the same word
      step(0, 1, mk(1, 1, 5'd4, 32'h2002, 32'h1C000014, 4'b0001), 32'h0, 1);
      drive(0, 1, mk(1, 1, 5'd5, 32'h2000, 32'h1C000018, 4'b0100), 32'h80017FFF, 1);
      chk("ldhu_final", MEM_to_WB_bus[63:32], 32'h00008001);
      tick();
      drive(0, 0, nop, 32'h80017FFF, 1);
      chk("ldh_final", MEM_to_WB_bus[63:32], 32'h00007FFF);
      tick();

      // word load held across a 3-cycle WB stall while SRAM output changes
      step(0, 1, mk(1, 1, 5'd6, 32'h3000, 32'h1C00001C, 4'b0000), 32'h0, 1);
      drive(0, 1, mk(0, 1, 5'd7, 32'h55, 32'h1C000020, 4'b0000), 32'hDEADBEEF, 0);
      chk("stall_allow0", MEM_allow, 1'b0);
      tick();
      step(0, 1, mk(0, 1, 5'd7, 32'h55, 32'h1C000020, 4'b0000), 32'h11111111, 0);
      drive(0, 1, mk(0, 1, 5'd7, 32'h55, 32'h1C000020, 4'b0000), 32'h11111111, 0);
      chk("stall_allow2", MEM_allow, 1'b0);
      tick();
      drive(0, 1, mk(0, 1, 5'd7, 32'h55, 32'h1C000020, 4'b0000), 32'h11111111, 1);
      chk("stall_final", MEM_to_WB_bus[63:32], 32'hDEADBEEF);
      tick();
      step(0, 0, nop, 32'h0, 1);

      // back-to-back ALU ops
      step(0, 1, mk(0, 1, 5'd9, 32'hCAFE0001, 32'h1C000000, 4'b0000), 32'h0, 1);
      drive(0, 1, mk(0, 1, 5'd10, 32'hCAFE0002, 32'h1C000004, 4'b0000), 32'h0, 1);
      chk("alu1_pc", MEM_to_WB_bus[31:0], 32'h1C000000);
      chk("alu1_res", MEM_to_WB_bus[63:32], 32'hCAFE0001);
      tick();
      drive(0, 0, nop, 32'h0, 1);
      chk("alu2_valid", MEM_to_WB_valid, 1'b1);
      chk("alu2_pc", MEM_to_WB_bus[31:0], 32'h1C000004);
      chk("alu2_fwd_dest", MEM_to_ID_forward[36:32], 5'd10);
      tick();
      drive(0, 0, nop, 32'h0, 1);
      chk("empty_fwd_dest", MEM_to_ID_forward[36:32], 5'd0);
      tick();

      // reset during a held load drops it and clears the hold
      step(0, 1, mk(1, 1, 5'd11, 32'h4000, 32'h1C000030, 4'b0000), 32'h0, 1);
      step(0, 0, nop, 32'hAAAA5555, 0);
      step(1, 0, nop, 32'h0, 0);
      drive(0, 1, mk(1, 1, 5'd12, 32'h4004, 32'h1C000034, 4'b0000), 32'h0, 1);
      chk("rstmid_valid", MEM_to_WB_valid, 1'b0);
      chk("rstmid_fwd_we", MEM_to_ID_forward[37], 1'b0);
      tick();
      drive(0, 0, nop, 32'h12345678, 1);
      chk("rstmid_live", MEM_to_WB_bus[63:32], 32'h12345678);
      tick();

      // misaligned ld_h
      step(0, 1, mk(1, 1, 5'd13, 32'h5003, 32'h1C000040, 4'b0100), 32'h0, 1);
      drive(0, 0, nop, 32'h89ABCDEF, 1);
`ifdef MEM_ALIGN_CHECK_EN
      chk("ale_flag", mem_ale, 1'b1);
      chk("ale_we", MEM_to_WB_bus[69], 1'b0);
`else
      chk("ale_flag", mem_ale, 1'b0);
      chk("ale_we", MEM_to_WB_bus[69], 1'b1);
`endif
      tick();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         int k;
         k  = $urandom_range(0, 4);
         ld = mk(1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
                 (k == 0) ? 4'b0000 : 4'(1 << (k - 1)));
         step(($urandom_range(0, 39) == 0), 1'($urandom), ld, $urandom,
              ($urandom_range(0, 2) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
